// File: rtl/b06_pkg.sv
// b06_pkg: shared types and default constants for the b06 EQL counter stage.
//   state_t          - controller-facing FSM state (IDLE/COUNT/MATCH), 2 bits
//   CNT_W_DEF        - default counter/target width
//   TARGET_RST_DEF   - default target value after reset
//   TIMEOUT_CYC_DEF  - default MATCH hold limit (B06_EQL_TIMEOUT_EN builds only)
package b06_pkg;

  localparam int CNT_W_DEF       = 4;
  localparam int TARGET_RST_DEF  = 5;
  localparam int TIMEOUT_CYC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_MATCH = 2'd2
  } state_t;

endpackage

// File: rtl/b06_ack_timer.sv
// b06_ack_timer: loadable down-counter with terminal detect.
//   gclk, grst_n : clock, async active-low reset
//   load         : load LOAD_VAL (takes priority over dec)
//   dec          : decrement by one, saturating at zero
//   zero         : counter currently at zero
module b06_ack_timer #(
  parameter int           W        = 4,
  parameter logic [W-1:0] LOAD_VAL = '0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                   cnt_q <= '0;
    else if (load)                 cnt_q <= LOAD_VAL;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/b06_eql_counter.sv
// b06_eql_counter: comparator/counter feeding the b06 interrupt-handler
// controller. Produces EQL (count == target) and CONT_EQL (EQL held two
// consecutive cycles); consumes ENABLE_COUNT and ACKOUT from the controller.
// The target is loaded over a valid/ready handshake, accepted only in IDLE.
//
// Ports:
//   CLOCK, RESET_N           : clock (rising edge), async active-low reset
//   LOAD_VALID/DATA/READY    : target load handshake
//   ENABLE_COUNT, ACKOUT     : controller inputs
//   EQL, CONT_EQL            : equality flags, decoded from registers only
//   COUNT                    : current counter value
//   OVF                      : sticky wrap flag
//   TIMEOUT                  : one-cycle forced-release pulse
//
// Optional feature macro: B06_EQL_TIMEOUT_EN. When defined, MATCH is released
// after TIMEOUT_CYC cycles without ACKOUT and the TIMEOUT port exists.
module b06_eql_counter
  import b06_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TARGET_RST = CNT_W'(TARGET_RST_DEF)
`ifdef B06_EQL_TIMEOUT_EN
  , parameter int             TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             LOAD_VALID,
  input  logic [CNT_W-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  input  logic             ENABLE_COUNT,
  input  logic             ACKOUT,
  output logic             EQL,
  output logic             CONT_EQL,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
`ifdef B06_EQL_TIMEOUT_EN
  , output logic           TIMEOUT
`endif
);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] target_q;
  logic             eql_q;
  logic             ovf_q;
  logic             at_target;

  assign at_target  = (count_q == target_q);
  assign LOAD_READY = (state_q == ST_IDLE);
  assign EQL        = (state_q != ST_IDLE) && at_target;
  assign CONT_EQL   = EQL && eql_q;
  assign COUNT      = count_q;
  assign OVF        = ovf_q;

`ifdef B06_EQL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic tmr_zero;
  logic tmr_load;
  logic timeout_q;

  // Arm on the COUNT->MATCH transition so the first MATCH cycle sees
  // TIMEOUT_CYC-1 and the terminal count lands on the last allowed cycle.
  assign tmr_load = (state_q == ST_COUNT) && !ACKOUT && at_target;

  b06_ack_timer #(
    .W        (TW),
    .LOAD_VAL (TW'(TIMEOUT_CYC - 1))
  ) u_ack_timer (
    .gclk   (CLOCK),
    .grst_n (RESET_N),
    .load   (tmr_load),
    .dec    (state_q == ST_MATCH),
    .zero   (tmr_zero)
  );

  assign TIMEOUT = timeout_q;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      target_q  <= TARGET_RST;
      eql_q     <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef B06_EQL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      eql_q <= EQL;
`ifdef B06_EQL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          // A load wins over ENABLE_COUNT in the same cycle.
          if (LOAD_VALID) begin
            target_q <= LOAD_DATA;
            count_q  <= '0;
            ovf_q    <= 1'b0;
          end else if (ENABLE_COUNT) begin
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (ACKOUT) begin
            count_q <= '0;
            state_q <= ST_IDLE;
          end else if (at_target) begin
            state_q <= ST_MATCH;
          end else if (ENABLE_COUNT) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == '1) ovf_q <= 1'b1;
          end
        end
        ST_MATCH: begin
          if (ACKOUT) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
`ifdef B06_EQL_TIMEOUT_EN
          else if (tmr_zero) begin
            timeout_q <= 1'b1;
            count_q   <= '0;
            state_q   <= ST_IDLE;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b06_eql_counter.sv
module tb_b06_eql_counter;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       LOAD_VALID = 1'b0;
  logic [3:0] LOAD_DATA = 4'd0;
  logic       LOAD_READY;
  logic       ENABLE_COUNT = 1'b0;
  logic       ACKOUT = 1'b0;
  logic       EQL, CONT_EQL, OVF;
  logic [3:0] COUNT;
`ifdef B06_EQL_TIMEOUT_EN
  logic       TIMEOUT;
`endif

  int total = 0;
  int bad   = 0;

  b06_eql_counter dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .LOAD_VALID   (LOAD_VALID),
    .LOAD_DATA    (LOAD_DATA),
    .LOAD_READY   (LOAD_READY),
    .ENABLE_COUNT (ENABLE_COUNT),
    .ACKOUT       (ACKOUT),
    .EQL          (EQL),
    .CONT_EQL     (CONT_EQL),
    .COUNT        (COUNT),
    .OVF          (OVF)
`ifdef B06_EQL_TIMEOUT_EN
    , .TIMEOUT    (TIMEOUT)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural reference: phase 0=idle, 1=counting, 2=matched.
  int m_ph, m_cnt, m_tgt, m_ovf, m_eqlq, m_mcyc, m_tmo;

  function automatic int m_eql();
    return (m_ph != 0 && m_cnt == m_tgt) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_tgt = 5; m_ovf = 0; m_eqlq = 0; m_mcyc = 0; m_tmo = 0;
  endtask

  task automatic model_update();
    m_eqlq = m_eql();
    m_tmo  = 0;
    case (m_ph)
      0: begin
        if (LOAD_VALID) begin
          m_tgt = int'(LOAD_DATA); m_cnt = 0; m_ovf = 0;
        end else if (ENABLE_COUNT) m_ph = 1;
      end
      1: begin
        if (ACKOUT) begin m_cnt = 0; m_ph = 0; end
        else if (m_cnt == m_tgt) begin m_ph = 2; m_mcyc = 0; end
        else if (ENABLE_COUNT) begin
          if (m_cnt == 15) m_ovf = 1;
          m_cnt = (m_cnt + 1) % 16;
        end
      end
      default: begin
        m_mcyc++;
        if (ACKOUT) begin m_cnt = 0; m_ovf = 0; m_ph = 0; end
`ifdef B06_EQL_TIMEOUT_EN
        else if (m_mcyc == 8) begin m_tmo = 1; m_cnt = 0; m_ph = 0; end
`endif
      end
    endcase
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_update();
    @(posedge CLOCK); #1;
  endtask

  task automatic ack_and_idle();
    ENABLE_COUNT = 1'b0; ACKOUT = 1'b1; tick(); ACKOUT = 1'b0; tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #2;
    total++; if (COUNT !== 4'd0 || EQL !== 1'b0 || CONT_EQL !== 1'b0) begin
      bad++; $display("FAIL rst_outs count=%0d eql=%b cont=%b exp 0/0/0", COUNT, EQL, CONT_EQL);
    end
    total++; if (LOAD_READY !== 1'b1 || OVF !== 1'b0) begin
      bad++; $display("FAIL rst_ready ready=%b ovf=%b exp 1/0", LOAD_READY, OVF);
    end
    @(posedge CLOCK); #1; RESET_N = 1'b1;
    ENABLE_COUNT = 1'b1;
    repeat (4) tick();
    total++; if (COUNT !== 4'd3 || LOAD_READY !== 1'b0) begin
      bad++; $display("FAIL rst_precount count=%0d ready=%b exp 3/0", COUNT, LOAD_READY);
    end
    // Asynchronous reset mid-COUNT must take effect without a clock edge.
    RESET_N = 1'b0; #1;
    total++; if (COUNT !== 4'd0 || EQL !== 1'b0 || LOAD_READY !== 1'b1) begin
      bad++; $display("FAIL rst_async count=%0d eql=%b ready=%b exp 0/0/1", COUNT, EQL, LOAD_READY);
    end
    @(posedge CLOCK); #1; RESET_N = 1'b1;
    // Default target 5 must be back: first EQL should show COUNT=5.
    begin
      int n = 0;
      while (EQL !== 1'b1 && n < 20) begin tick(); n++; end
      total++; if (EQL !== 1'b1 || COUNT !== 4'd5) begin
        bad++; $display("FAIL rst_target eql=%b count=%0d exp 1/5", EQL, COUNT);
      end
    end
    ack_and_idle();
  endtask

  task automatic test_count_to_target();
    logic [3:0] exp_c [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    logic       exp_e [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_q [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    LOAD_VALID = 1'b1; LOAD_DATA = 4'd3; tick(); LOAD_VALID = 1'b0;
    ENABLE_COUNT = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (COUNT !== exp_c[i] || EQL !== exp_e[i] || CONT_EQL !== exp_q[i]) begin
        bad++; $display("FAIL cnt3 step=%0d got c=%0d e=%b q=%b exp c=%0d e=%b q=%b",
                        i, COUNT, EQL, CONT_EQL, exp_c[i], exp_e[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ack();
    ENABLE_COUNT = 1'b0; ACKOUT = 1'b1; tick(); ACKOUT = 1'b0;
    total++; if (LOAD_READY !== 1'b1 || COUNT !== 4'd0 || EQL !== 1'b0 || CONT_EQL !== 1'b0) begin
      bad++; $display("FAIL ack ready=%b c=%0d e=%b q=%b exp 1/0/0/0", LOAD_READY, COUNT, EQL, CONT_EQL);
    end
  endtask

  task automatic test_enable_toggle();
    logic       en_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_c  [4] = '{4'd0, 4'd1, 4'd1, 4'd2};
    logic       exp_e  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    LOAD_VALID = 1'b1; LOAD_DATA = 4'd2; tick(); LOAD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ENABLE_COUNT = en_seq[i];
      tick();
      total++; if (COUNT !== exp_c[i] || EQL !== exp_e[i]) begin
        bad++; $display("FAIL toggle step=%0d got c=%0d e=%b exp c=%0d e=%b",
                        i, COUNT, EQL, exp_c[i], exp_e[i]);
      end
    end
    ack_and_idle();
  endtask

  task automatic test_load_priority();
    LOAD_VALID = 1'b1; LOAD_DATA = 4'd0; ENABLE_COUNT = 1'b1; tick();
    LOAD_VALID = 1'b0;
    total++; if (LOAD_READY !== 1'b1 || EQL !== 1'b0) begin
      bad++; $display("FAIL ldprio ready=%b eql=%b exp 1/0", LOAD_READY, EQL);
    end
    tick();
    total++; if (LOAD_READY !== 1'b0 || EQL !== 1'b1 || CONT_EQL !== 1'b0 || COUNT !== 4'd0) begin
      bad++; $display("FAIL tgt0_first ready=%b e=%b q=%b c=%0d exp 0/1/0/0", LOAD_READY, EQL, CONT_EQL, COUNT);
    end
    tick();
    total++; if (EQL !== 1'b1 || CONT_EQL !== 1'b1) begin
      bad++; $display("FAIL tgt0_match e=%b q=%b exp 1/1", EQL, CONT_EQL);
    end
    ack_and_idle();
  endtask

`ifdef B06_EQL_TIMEOUT_EN
  task automatic test_timeout();
    for (int run = 0; run < 2; run++) begin
      LOAD_VALID = 1'b1; LOAD_DATA = 4'd1; tick(); LOAD_VALID = 1'b0;
      ENABLE_COUNT = 1'b1; tick(); tick(); tick();
      ENABLE_COUNT = 1'b0;
      // Now in the first MATCH cycle.
      for (int k = 1; k <= 8; k++) begin
        total++; if (LOAD_READY !== 1'b0 || TIMEOUT !== 1'b0) begin
          bad++; $display("FAIL tmo_hold run=%0d k=%0d ready=%b tmo=%b exp 0/0", run, k, LOAD_READY, TIMEOUT);
        end
        ACKOUT = (run == 1 && k == 8);
        tick();
      end
      ACKOUT = 1'b0;
      total++; if (TIMEOUT !== (run == 0) || LOAD_READY !== 1'b1 || COUNT !== 4'd0) begin
        bad++; $display("FAIL tmo_fire run=%0d tmo=%b ready=%b c=%0d exp %0d/1/0", run, TIMEOUT, LOAD_READY, COUNT, run == 0);
      end
      tick();
      total++; if (TIMEOUT !== 1'b0) begin
        bad++; $display("FAIL tmo_pulse run=%0d tmo=%b exp 0", run, TIMEOUT);
      end
    end
  endtask
`endif

  task automatic test_random();
    LOAD_VALID = 1'b0; ENABLE_COUNT = 1'b0; ACKOUT = 1'b0;
    RESET_N = 1'b0; #1; RESET_N = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      LOAD_VALID   = ($urandom_range(0, 4) == 0);
      LOAD_DATA    = 4'($urandom_range(0, 15));
      ENABLE_COUNT = $urandom_range(0, 1) != 0;
      ACKOUT       = ($urandom_range(0, 5) == 0);
      tick();
      total++; if (int'(COUNT) != m_cnt || int'(EQL) != m_eql() ||
                   int'(CONT_EQL) != (m_eql() & m_eqlq) ||
                   int'(LOAD_READY) != (m_ph == 0 ? 1 : 0) || int'(OVF) != m_ovf) begin
        bad++; $display("FAIL rnd i=%0d got c=%0d e=%b q=%b r=%b o=%b exp c=%0d e=%0d q=%0d r=%0d o=%0d",
                        i, COUNT, EQL, CONT_EQL, LOAD_READY, OVF, m_cnt, m_eql(),
                        m_eql() & m_eqlq, m_ph == 0, m_ovf);
      end
`ifdef B06_EQL_TIMEOUT_EN
      total++; if (int'(TIMEOUT) != m_tmo) begin
        bad++; $display("FAIL rnd_tmo i=%0d got=%b exp=%0d", i, TIMEOUT, m_tmo);
      end
`endif
    end
    LOAD_VALID = 1'b0; ENABLE_COUNT = 1'b0; ACKOUT = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_to_target();
    test_ack();
    test_enable_toggle();
    test_load_priority();
`ifdef B06_EQL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b06_eql_counter.md
Name: b06_eql_counter

Overview:
- Comparator/counter stage that feeds the b06 interrupt-handler controller.
- Generates the EQL input (count equals target) and the CONT_EQL input (equality held for at least two consecutive cycles).
- Consumes the controller's ENABLE_COUNT and ACKOUT outputs.
- Target value is loaded through a valid/ready handshake from the configuration side.

Parameters:
- CNT_W, 4, width of the counter and target.
- TARGET_RST, 4'd5, target register value after reset.
- TIMEOUT_CYC, 8, cycles in MATCH before forced release; used only when B06_EQL_TIMEOUT_EN is defined.

Ports:
- CLOCK  input  1  single clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- LOAD_VALID  input  1  new target offered.
- LOAD_DATA  input  CNT_W  target value.
- LOAD_READY  output  1  target can be accepted.
- ENABLE_COUNT  input  1  count-enable from the controller.
- ACKOUT  input  1  acknowledge from the controller; clears the match.
- EQL  output  1  count equals target.
- CONT_EQL  output  1  EQL high in this cycle and the previous cycle.
- COUNT  output  CNT_W  current counter value.
- OVF  output  1  sticky wrap flag.
- TIMEOUT  output  1  one-cycle pulse; exists only with B06_EQL_TIMEOUT_EN.

Behaviour:
- Reset, asynchronous, with RESET_N low:
  - state=IDLE, COUNT=0, target=TARGET_RST, eql_q=0, OVF=0, TIMEOUT=0.
  - Combinational outputs at reset: EQL=0, CONT_EQL=0, LOAD_READY=1.
- Reset asserted mid-operation aborts immediately to these values. No pending load survives.
- States: IDLE, COUNT, MATCH (2-bit encoding).
- Output decode:
  - LOAD_READY = (state==IDLE).
  - EQL = (state!=IDLE) && (COUNT==target), decoded from registers only, with no input-to-output path.
  - CONT_EQL = EQL && eql_q, where eql_q <= EQL every cycle.
- IDLE:
  - LOAD_VALID&&LOAD_READY: target<=LOAD_DATA, COUNT<=0, OVF<=0, stay IDLE. Load has priority over ENABLE_COUNT in the same cycle.
  - Else if ENABLE_COUNT=1: go to COUNT. COUNT is unchanged, so counting begins the next cycle.
- COUNT, evaluated in priority order:
  1. ACKOUT=1: COUNT<=0, go to IDLE.
  2. COUNT==target: go to MATCH, hold COUNT. This applies regardless of ENABLE_COUNT.
  3. ENABLE_COUNT=1: COUNT<=COUNT+1 modulo 2^CNT_W. On wrap from all-ones to 0, set OVF<=1.
  4. Otherwise hold.
- Target=0 case: EQL rises the first cycle in COUNT, and the state moves to MATCH on the next edge.
- MATCH:
  - COUNT is frozen and ENABLE_COUNT is ignored.
  - EQL=1 throughout; CONT_EQL=1 from the second MATCH cycle onward.
  - ACKOUT=1: COUNT<=0, OVF<=0, go to IDLE. EQL drops the next cycle.
- LOAD_VALID outside IDLE is not accepted. The source must hold LOAD_VALID/LOAD_DATA stable until LOAD_READY.
- OVF is cleared only by reset, by a target load, or by ACKOUT in MATCH.
- Latency: ENABLE_COUNT edge to first increment is 2 cycles. Target T reached from 0 after 1+T enabled cycles.

Optional Feature:
- Macro: B06_EQL_TIMEOUT_EN.
- With it defined:
  - A down-counter loads TIMEOUT_CYC-1 on MATCH entry and decrements each MATCH cycle.
  - If it reaches 0 without ACKOUT, TIMEOUT pulses high for 1 cycle, COUNT<=0, and the state goes to IDLE.
  - ACKOUT in the same cycle wins, and no TIMEOUT pulse is issued.
- Without it: the TIMEOUT port and the timer logic are absent, and MATCH is held indefinitely until ACKOUT.

Decomposition:
- Package b06_pkg holds:
  - the state typedef (IDLE/COUNT/MATCH), 2 bits;
  - the default CNT_W constant;
  - the TARGET_RST and TIMEOUT_CYC default constants.
- One sub-module, b06_ack_timer, implements the loadable down-counter with a terminal pulse. It is instantiated only under B06_EQL_TIMEOUT_EN.

Test Plan:
- Reset with RESET_N=0 mid-COUNT at COUNT=3 -> the same cycle shows COUNT=0, EQL=0, LOAD_READY=1, and target=5 restored.
- Load 4'd3 in IDLE, then hold ENABLE_COUNT=1 -> COUNT goes 0,1,2,3, EQL rises when COUNT=3, CONT_EQL rises 1 cycle later, and COUNT stays 3.
- In MATCH, pulse ACKOUT for 1 cycle -> next cycle shows state IDLE, COUNT=0, EQL=0, CONT_EQL=0.
- Target 4'd2 with ENABLE_COUNT toggling 1,0,1 -> COUNT goes 0,1,1,2, and EQL is asserted only at COUNT=2.
- LOAD_VALID=1 with LOAD_DATA=4'd0 and ENABLE_COUNT=1 in the same IDLE cycle -> the load is taken and the state stays IDLE. The next ENABLE_COUNT gives EQL=1 on the first COUNT cycle.
- With B06_EQL_TIMEOUT_EN and TIMEOUT_CYC=8, no ACKOUT -> TIMEOUT pulses on the 8th MATCH cycle, then IDLE. A second run with ACKOUT on cycle 8 produces no pulse.
